// File: rtl/wb_commit_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// wb_arb_pkg : shared widths, payload types and helpers for wb_commit_arbiter
// Rev 1.0
// ==========================================================================
package wb_arb_pkg;

  localparam int WB_NUM_REQ = 4;
  localparam int WB_ADDR_W  = 5;
  localparam int WB_DATA_W  = 32;
  localparam int WB_ID_W    = 3;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd_addr;
    logic                 rd_we;
    logic [WB_DATA_W-1:0] rd_data;
    logic [WB_ID_W-1:0]   commit_id;
  } wb_req_t;

  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_port_t;

  // x0 is hard-wired, so a write to it neither updates the file nor retires a scoreboard entry
  function automatic logic writes_reg(input wb_req_t r);
    return r.rd_we && (r.rd_addr != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_commit_arbiter_if.sv
`default_nettype none
// ==========================================================================
// wb_commit_arbiter_if : execution-unit results in, writeback/commit pairs out
// Rev 1.0
// ==========================================================================
interface wb_commit_arbiter_if #(
  parameter int NUM_REQ         = wb_arb_pkg::WB_NUM_REQ,
  parameter int REG_ADDR_WIDTH  = wb_arb_pkg::WB_ADDR_W,
  parameter int DATA_WIDTH      = wb_arb_pkg::WB_DATA_W,
  parameter int COMMIT_ID_WIDTH = wb_arb_pkg::WB_ID_W
);
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_rd_addr_i;
  logic [NUM_REQ-1:0]                 req_rd_we_i;
  logic [NUM_REQ*DATA_WIDTH-1:0]      req_rd_data_i;
  logic [NUM_REQ*COMMIT_ID_WIDTH-1:0] req_commit_id_i;
  logic                               wb0_we_o;
  logic [REG_ADDR_WIDTH-1:0]          wb0_addr_o;
  logic [DATA_WIDTH-1:0]              wb0_data_o;
  logic                               wb1_we_o;
  logic [REG_ADDR_WIDTH-1:0]          wb1_addr_o;
  logic [DATA_WIDTH-1:0]              wb1_data_o;
  logic                               commit_valid_o;
  logic [COMMIT_ID_WIDTH-1:0]         commit_id_o;
  logic                               commit_valid2_o;
  logic [COMMIT_ID_WIDTH-1:0]         commit_id2_o;

  modport master (
    output req_valid_i, req_rd_addr_i, req_rd_we_i, req_rd_data_i, req_commit_id_i,
    input  req_ready_o, wb0_we_o, wb0_addr_o, wb0_data_o, wb1_we_o, wb1_addr_o,
           wb1_data_o, commit_valid_o, commit_id_o, commit_valid2_o, commit_id2_o
  );

  modport slave (
    input  req_valid_i, req_rd_addr_i, req_rd_we_i, req_rd_data_i, req_commit_id_i,
    output req_ready_o, wb0_we_o, wb0_addr_o, wb0_data_o, wb1_we_o, wb1_addr_o,
           wb1_data_o, commit_valid_o, commit_id_o, commit_valid2_o, commit_id2_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_commit_arbiter_rr_pick2.sv
`default_nettype none
// ==========================================================================
// rr_pick2 : combinational round-robin picker issuing up to two grants
// Rev 1.0
// ==========================================================================
module rr_pick2 #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic [N-1:0]     i_conflict,
  output logic [N-1:0]     o_grant0,
  output logic [N-1:0]     o_grant1,
  output logic             o_valid0,
  output logic             o_valid1
);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  // Grant 1 lives in its own process: the conflict mask is derived from grant 0 outside
  always_comb begin : p_pick0
    o_grant0 = '0;
    o_valid0 = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid0 && i_req[wrap_idx(i_ptr, k)]) begin
        o_grant0[wrap_idx(i_ptr, k)] = 1'b1;
        o_valid0                     = 1'b1;
      end
    end
  end

  always_comb begin : p_pick1
    o_grant1 = '0;
    o_valid1 = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid1 && i_req[wrap_idx(i_ptr, k)] && !o_grant0[wrap_idx(i_ptr, k)]
          && !i_conflict[wrap_idx(i_ptr, k)]) begin
        o_grant1[wrap_idx(i_ptr, k)] = 1'b1;
        o_valid1                     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_commit_arbiter.sv
`default_nettype none
// ==========================================================================
// wb_commit_arbiter : buffers one result per unit, retires up to two per cycle
// Rev 1.0
// ==========================================================================
module wb_commit_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ         = WB_NUM_REQ,
  parameter int REG_ADDR_WIDTH  = WB_ADDR_W,
  parameter int DATA_WIDTH      = WB_DATA_W,
  parameter int COMMIT_ID_WIDTH = WB_ID_W
) (
  input logic                clk,
  input logic                rst_n,
  wb_commit_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  wb_req_t                    r_hold [NUM_REQ];
  logic [NUM_REQ-1:0]         r_hold_v;
  logic [PTR_W-1:0]           r_ptr;
  wb_port_t                   r_wb0;
  wb_port_t                   r_wb1;
  logic                       r_cv0;
  logic                       r_cv1;
  logic [COMMIT_ID_WIDTH-1:0] r_cid0;
  logic [COMMIT_ID_WIDTH-1:0] r_cid1;

  wb_req_t                    w_in [NUM_REQ];
  logic [NUM_REQ-1:0]         w_grant0, w_grant1, w_grant, w_conflict, w_load, w_ready;
  logic                       w_valid0, w_valid1;
  wb_req_t                    w_slot0, w_slot1;
  logic [PTR_W-1:0]           w_last, w_next_ptr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_in[gi] = {bus.req_rd_addr_i[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                       bus.req_rd_we_i[gi],
                       bus.req_rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH],
                       bus.req_commit_id_i[gi*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH]};
  end

  rr_pick2 #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req      (r_hold_v),
    .i_ptr      (r_ptr),
    .i_conflict (w_conflict),
    .o_grant0   (w_grant0),
    .o_grant1   (w_grant1),
    .o_valid0   (w_valid0),
    .o_valid1   (w_valid1)
  );

  always_comb begin : p_slot0
    w_slot0 = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_grant0[i]) w_slot0 = r_hold[i];
  end

  always_comb begin : p_slot1
    w_slot1 = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_grant1[i]) w_slot1 = r_hold[i];
  end

  // Two same-cycle writes to one register would race in the file; defer the later one
  always_comb begin : p_conflict
    w_conflict = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_conflict[i] = writes_reg(r_hold[i]) && writes_reg(w_slot0)
                      && (r_hold[i].rd_addr == w_slot0.rd_addr);
    end
  end

  always_comb begin : p_next_ptr
    w_last = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_valid1 ? w_grant1[i] : w_grant0[i]) w_last = PTR_W'(i);
    end
    if (!w_valid0)                            w_next_ptr = r_ptr;
    else if (w_last == PTR_W'(NUM_REQ - 1))   w_next_ptr = '0;
    else                                      w_next_ptr = w_last + 1'b1;
  end

  assign w_grant = w_grant0 | w_grant1;
  assign w_ready = ~r_hold_v | w_grant;
  assign w_load  = bus.req_valid_i & w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_v <= '0;
      r_ptr    <= '0;
      r_wb0    <= '0;
      r_wb1    <= '0;
      r_cv0    <= 1'b0;
      r_cv1    <= 1'b0;
      r_cid0   <= '0;
      r_cid1   <= '0;
    end else begin
      r_hold_v <= w_load | (r_hold_v & ~w_grant);
      r_ptr    <= w_next_ptr;
      r_wb0    <= '{we: writes_reg(w_slot0), addr: w_slot0.rd_addr, data: w_slot0.rd_data};
      r_wb1    <= '{we: writes_reg(w_slot1), addr: w_slot1.rd_addr, data: w_slot1.rd_data};
      r_cv0    <= writes_reg(w_slot0);
      r_cv1    <= writes_reg(w_slot1);
      r_cid0   <= w_slot0.commit_id;
      r_cid1   <= w_slot1.commit_id;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) if (w_load[i]) r_hold[i] <= w_in[i];
  end

  assign bus.req_ready_o     = w_ready;
  assign bus.wb0_we_o        = r_wb0.we;
  assign bus.wb0_addr_o      = r_wb0.addr;
  assign bus.wb0_data_o      = r_wb0.data;
  assign bus.wb1_we_o        = r_wb1.we;
  assign bus.wb1_addr_o      = r_wb1.addr;
  assign bus.wb1_data_o      = r_wb1.data;
  assign bus.commit_valid_o  = r_cv0;
  assign bus.commit_id_o     = r_cid0;
  assign bus.commit_valid2_o = r_cv1;
  assign bus.commit_id2_o    = r_cid1;

  a_commit_ids_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.commit_valid_o && bus.commit_valid2_o) |-> (bus.commit_id_o != bus.commit_id2_o));

  for (genvar ga = 0; ga < NUM_REQ; ga++) begin : g_valid_hold
    a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_valid_i[ga] && !bus.req_ready_o[ga]) |=> bus.req_valid_i[ga]);
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_wb_commit_arbiter : directed scenarios plus random traffic vs a reference model
// Rev 1.0
// ==========================================================================
module tb_wb_commit_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_commit_arbiter_if #(.NUM_REQ(N), .REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMMIT_ID_WIDTH(IW)) bus ();

  wb_commit_arbiter #(.NUM_REQ(N), .REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMMIT_ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: set of held results and the next search start
  bit            m_held [N];
  bit            m_we   [N];
  logic [AW-1:0] m_rd   [N];
  logic [DW-1:0] m_data [N];
  logic [IW-1:0] m_id   [N];
  int            m_ptr;

  logic          e_we0, e_we1, e_cv0, e_cv1;
  logic [AW-1:0] e_addr0, e_addr1;
  logic [DW-1:0] e_data0, e_data1;
  logic [IW-1:0] e_id0, e_id1;
  logic [N-1:0]  e_ready, a_ready, t_acc;

  function automatic bit writes(input int c);
    return m_we[c] && (m_rd[c] != '0);
  endfunction

  task automatic set_req(input int u, input logic v, input logic [AW-1:0] rd, input logic we,
                         input logic [DW-1:0] d, input logic [IW-1:0] id);
    bus.req_valid_i[u]             = v;
    bus.req_rd_addr_i[u*AW +: AW]  = rd;
    bus.req_rd_we_i[u]             = we;
    bus.req_rd_data_i[u*DW +: DW]  = d;
    bus.req_commit_id_i[u*IW +: IW] = id;
  endtask

  task automatic clear_all();
    bus.req_valid_i     = '0;
    bus.req_rd_addr_i   = '0;
    bus.req_rd_we_i     = '0;
    bus.req_rd_data_i   = '0;
    bus.req_commit_id_i = '0;
  endtask

  // One clock: pick winners from the held set, record acceptances, then advance
  task automatic tick();
    int            order[$];
    int            s0, s1, last;
    logic [AW-1:0] in_rd   [N];
    logic          in_we   [N];
    logic [DW-1:0] in_data [N];
    logic [IW-1:0] in_id   [N];
    s0 = -1;
    s1 = -1;
    for (int k = 0; k < N; k++) if (m_held[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    if (order.size() > 0) s0 = order[0];
    for (int j = 1; j < order.size(); j++) begin
      if (s1 < 0 && !(writes(order[j]) && writes(s0) && m_rd[order[j]] == m_rd[s0])) s1 = order[j];
    end
    for (int i = 0; i < N; i++) begin
      e_ready[i] = !m_held[i] || i == s0 || i == s1;
      t_acc[i]   = bus.req_valid_i[i] && e_ready[i];
      in_rd[i]   = bus.req_rd_addr_i[i*AW +: AW];
      in_we[i]   = bus.req_rd_we_i[i];
      in_data[i] = bus.req_rd_data_i[i*DW +: DW];
      in_id[i]   = bus.req_commit_id_i[i*IW +: IW];
    end
    a_ready = bus.req_ready_o;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_held[i] = 1'b0;
      m_ptr = 0;
      e_we0 = 1'b0; e_cv0 = 1'b0; e_we1 = 1'b0; e_cv1 = 1'b0;
      t_acc = '0;
    end else begin
      e_we0 = (s0 >= 0) && writes(s0);
      e_cv0 = e_we0;
      e_we1 = (s1 >= 0) && writes(s1);
      e_cv1 = e_we1;
      if (s0 >= 0) begin e_addr0 = m_rd[s0]; e_data0 = m_data[s0]; e_id0 = m_id[s0]; m_held[s0] = 1'b0; end
      if (s1 >= 0) begin e_addr1 = m_rd[s1]; e_data1 = m_data[s1]; e_id1 = m_id[s1]; m_held[s1] = 1'b0; end
      for (int i = 0; i < N; i++) begin
        if (t_acc[i]) begin
          m_held[i] = 1'b1; m_rd[i] = in_rd[i]; m_we[i] = in_we[i];
          m_data[i] = in_data[i]; m_id[i] = in_id[i];
        end
      end
      last = (s1 >= 0) ? s1 : s0;
      if (last >= 0) m_ptr = (last + 1) % N;
    end
  endtask

  task automatic test_reset();
    clear_all();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.commit_valid_o, bus.wb1_we_o, bus.commit_valid2_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_valids: got %b expected 0000",
               {bus.wb0_we_o, bus.commit_valid_o, bus.wb1_we_o, bus.commit_valid2_o});
    end
    checks++;
    if ({bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o, bus.wb1_addr_o, bus.wb1_data_o, bus.commit_id2_o} !== '0) begin
      failures++;
      $display("FAIL reset_fields: addr0=%h data0=%h id0=%h addr1=%h data1=%h id1=%h expected all 0",
               bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o, bus.wb1_addr_o, bus.wb1_data_o, bus.commit_id2_o);
    end
    checks++;
    if (bus.req_ready_o !== 4'hF) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1111", bus.req_ready_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_four();
    for (int u = 0; u < N; u++) set_req(u, 1'b1, AW'(u + 1), 1'b1, DW'(32'h100 + u), IW'(u));
    tick();
    clear_all();
    tick();
    checks++;
    if (a_ready !== 4'b0011) begin failures++; $display("FAIL all4_ready_c1: got %b expected 0011", a_ready); end
    checks++;
    if ({bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_valid_o, bus.commit_id_o} !== {1'b1, 5'd1, 32'h100, 1'b1, 3'd0}) begin
      failures++; $display("FAIL all4_port0_c1: we=%b addr=%0d data=%h cv=%b id=%0d expected 1/1/100/1/0",
                           bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_valid_o, bus.commit_id_o);
    end
    checks++;
    if ({bus.wb1_we_o, bus.wb1_addr_o, bus.wb1_data_o, bus.commit_valid2_o, bus.commit_id2_o} !== {1'b1, 5'd2, 32'h101, 1'b1, 3'd1}) begin
      failures++; $display("FAIL all4_port1_c1: we=%b addr=%0d data=%h cv=%b id=%0d expected 1/2/101/1/1",
                           bus.wb1_we_o, bus.wb1_addr_o, bus.wb1_data_o, bus.commit_valid2_o, bus.commit_id2_o);
    end
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.wb0_addr_o, bus.commit_id_o, bus.wb1_we_o, bus.wb1_addr_o, bus.commit_id2_o}
        !== {1'b1, 5'd3, 3'd2, 1'b1, 5'd4, 3'd3}) begin
      failures++; $display("FAIL all4_c2: addr0=%0d id0=%0d addr1=%0d id1=%0d expected 3/2/4/3",
                           bus.wb0_addr_o, bus.commit_id_o, bus.wb1_addr_o, bus.commit_id2_o);
    end
    // Pointer should be back at 0: unit 0 must win over unit 3
    set_req(3, 1'b1, 5'd10, 1'b1, 32'h33, 3'd5);
    set_req(0, 1'b1, 5'd11, 1'b1, 32'h00, 3'd6);
    tick();
    clear_all();
    tick();
    checks++;
    if ({bus.wb0_addr_o, bus.wb1_addr_o} !== {5'd11, 5'd10}) begin
      failures++; $display("FAIL all4_ptr_wrap: addr0=%0d addr1=%0d expected 11/10", bus.wb0_addr_o, bus.wb1_addr_o);
    end
  endtask

  task automatic test_same_rd();
    set_req(0, 1'b1, 5'd7, 1'b1, 32'hD0, 3'd1);
    set_req(1, 1'b1, 5'd7, 1'b1, 32'hD1, 3'd2);
    set_req(2, 1'b1, 5'd9, 1'b1, 32'hD2, 3'd4);
    tick();
    clear_all();
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o, bus.wb1_we_o, bus.wb1_addr_o, bus.wb1_data_o, bus.commit_id2_o}
        !== {1'b1, 5'd7, 32'hD0, 3'd1, 1'b1, 5'd9, 32'hD2, 3'd4}) begin
      failures++; $display("FAIL samerd_first: data0=%h id0=%0d data1=%h id1=%0d expected D0/1/D2/4",
                           bus.wb0_data_o, bus.commit_id_o, bus.wb1_data_o, bus.commit_id2_o);
    end
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o, bus.wb1_we_o, bus.commit_valid2_o}
        !== {1'b1, 5'd7, 32'hD1, 3'd2, 1'b0, 1'b0}) begin
      failures++; $display("FAIL samerd_second: we0=%b data0=%h id0=%0d we1=%b cv2=%b expected 1/D1/2/0/0",
                           bus.wb0_we_o, bus.wb0_data_o, bus.commit_id_o, bus.wb1_we_o, bus.commit_valid2_o);
    end
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 5'd5, 1'b1, 32'hA5, 3'd3);
    tick();
    clear_all();
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_valid_o, bus.commit_id_o}
        !== {1'b1, 5'd5, 32'hA5, 1'b1, 3'd3}) begin
      failures++; $display("FAIL single_port0: we=%b addr=%0d data=%h cv=%b id=%0d expected 1/5/A5/1/3",
                           bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_valid_o, bus.commit_id_o);
    end
    checks++;
    if ({bus.wb1_we_o, bus.commit_valid2_o} !== 2'b00) begin
      failures++; $display("FAIL single_port1: we1=%b cv2=%b expected 0/0", bus.wb1_we_o, bus.commit_valid2_o);
    end
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.commit_valid_o} !== 2'b00) begin
      failures++; $display("FAIL single_one_cycle: we0=%b cv=%b expected 0/0", bus.wb0_we_o, bus.commit_valid_o);
    end
  endtask

  task automatic test_nonwrite();
    set_req(3, 1'b1, 5'd12, 1'b0, 32'hEE, 3'd6);
    set_req(0, 1'b1, 5'd2,  1'b1, 32'h22, 3'd7);
    tick();
    clear_all();
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.commit_valid_o} !== 2'b00) begin
      failures++; $display("FAIL nonwrite_slot0: we0=%b cv=%b expected 0/0", bus.wb0_we_o, bus.commit_valid_o);
    end
    checks++;
    if ({bus.wb1_we_o, bus.wb1_addr_o, bus.commit_valid2_o, bus.commit_id2_o} !== {1'b1, 5'd2, 1'b1, 3'd7}) begin
      failures++; $display("FAIL nonwrite_slot1: we1=%b addr1=%0d cv2=%b id2=%0d expected 1/2/1/7",
                           bus.wb1_we_o, bus.wb1_addr_o, bus.commit_valid2_o, bus.commit_id2_o);
    end
    tick();
    checks++;
    if ({a_ready, bus.wb0_we_o, bus.wb1_we_o, bus.commit_valid_o, bus.commit_valid2_o} !== {4'hF, 4'b0}) begin
      failures++; $display("FAIL nonwrite_cleared: ready=%b we0=%b we1=%b expected 1111/0/0",
                           a_ready, bus.wb0_we_o, bus.wb1_we_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] prev_data;
    for (int k = 0; k < 8; k++) begin
      logic [DW-1:0] d;
      d = $urandom;
      set_req(0, 1'b1, AW'(k + 1), 1'b1, d, IW'(k));
      tick();
      checks++;
      if (a_ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d: got %b expected 1", k, a_ready[0]); end
      if (k > 0) begin
        checks++;
        if ({bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o} !== {1'b1, AW'(k), prev_data, IW'(k - 1)}) begin
          failures++; $display("FAIL b2b_commit k=%0d: we=%b addr=%0d data=%h id=%0d expected 1/%0d/%h/%0d",
                               k, bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o, k, prev_data, k - 1);
        end
      end
      prev_data = d;
    end
    clear_all();
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o} !== {1'b1, 5'd8, prev_data}) begin
      failures++; $display("FAIL b2b_last: we=%b addr=%0d data=%h expected 1/8/%h",
                           bus.wb0_we_o, bus.wb0_addr_o, bus.wb0_data_o, prev_data);
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 5'd3, 1'b1, 32'h30, 3'd1);
    set_req(1, 1'b1, 5'd4, 1'b1, 32'h40, 3'd2);
    set_req(2, 1'b1, 5'd5, 1'b1, 32'h50, 3'd3);
    tick();
    clear_all();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.wb0_we_o, bus.wb1_we_o, bus.commit_valid_o, bus.commit_valid2_o, bus.req_ready_o} !== {4'b0, 4'hF}) begin
      failures++; $display("FAIL rstmid_after_edge: we0=%b we1=%b cv=%b cv2=%b ready=%b expected 0/0/0/0/1111",
                           bus.wb0_we_o, bus.wb1_we_o, bus.commit_valid_o, bus.commit_valid2_o, bus.req_ready_o);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.wb0_we_o, bus.wb1_we_o, bus.commit_valid_o, bus.commit_valid2_o} !== 4'b0) begin
        failures++; $display("FAIL rstmid_stale k=%0d: we0=%b we1=%b cv=%b cv2=%b expected all 0",
                             k, bus.wb0_we_o, bus.wb1_we_o, bus.commit_valid_o, bus.commit_valid2_o);
      end
    end
  endtask

  task automatic test_random();
    bit pend [N];
    for (int u = 0; u < N; u++) pend[u] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int u = 0; u < N; u++) begin
        if (!pend[u]) begin
          if ($urandom_range(0, 99) < 45) begin
            bit occ [8];
            int pick, r;
            for (int t = 0; t < 8; t++) occ[t] = 1'b0;
            for (int v = 0; v < N; v++) begin
              if (m_held[v]) occ[m_id[v]] = 1'b1;
              if (v != u && bus.req_valid_i[v]) occ[bus.req_commit_id_i[v*IW +: IW]] = 1'b1;
            end
            r = $urandom_range(0, 7);
            pick = -1;
            for (int t = 0; t < 8; t++) if (pick < 0 && !occ[(r + t) % 8]) pick = (r + t) % 8;
            set_req(u, 1'b1, AW'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), $urandom, IW'(pick));
          end else begin
            bus.req_valid_i[u] = 1'b0;
          end
        end
      end
      tick();
      for (int u = 0; u < N; u++) pend[u] = bus.req_valid_i[u] && !t_acc[u];
      checks++;
      if (a_ready !== e_ready) begin
        failures++; $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, a_ready, e_ready);
      end
      checks++;
      if ({bus.wb0_we_o, bus.commit_valid_o, bus.wb1_we_o, bus.commit_valid2_o} !== {e_we0, e_cv0, e_we1, e_cv1}) begin
        failures++; $display("FAIL rand_valids cyc=%0d: got %b expected %b", cyc,
                             {bus.wb0_we_o, bus.commit_valid_o, bus.wb1_we_o, bus.commit_valid2_o}, {e_we0, e_cv0, e_we1, e_cv1});
      end
      if (e_we0) begin
        checks++;
        if ({bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o} !== {e_addr0, e_data0, e_id0}) begin
          failures++; $display("FAIL rand_port0 cyc=%0d: addr=%0d data=%h id=%0d expected %0d/%h/%0d",
                               cyc, bus.wb0_addr_o, bus.wb0_data_o, bus.commit_id_o, e_addr0, e_data0, e_id0);
        end
      end
      if (e_we1) begin
        checks++;
        if ({bus.wb1_addr_o, bus.wb1_data_o, bus.commit_id2_o} !== {e_addr1, e_data1, e_id1}) begin
          failures++; $display("FAIL rand_port1 cyc=%0d: addr=%0d data=%h id=%0d expected %0d/%h/%0d",
                               cyc, bus.wb1_addr_o, bus.wb1_data_o, bus.commit_id2_o, e_addr1, e_data1, e_id1);
        end
      end
    end
    clear_all();
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_held[i] = 1'b0;
    m_ptr = 0;
    test_reset();
    test_all_four();
    test_same_rd();
    test_single();
    test_nonwrite();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
